// File: rtl/axi_interconnect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_interconnect_pkg : crossbar-wide types, defaults and helpers          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package axi_interconnect_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } grant_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_interconnect_crossbar_grant_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_interconnect_crossbar_grant_ctrl_if : request/handshake/grant bundle  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface axi_interconnect_crossbar_grant_ctrl_if #(
  parameter int NUM = 8
);
  import axi_interconnect_pkg::*;

  localparam int WIDTH = idx_width(NUM);

  logic [NUM-1:0]   user_req;
  logic             chn_valid;
  logic             chn_ready;
  logic             chn_last;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_id;
  logic [NUM-1:0]   grant_oh;
  logic             timeout_err;
  logic [WIDTH-1:0] timeout_id;

  // Controller side: consumes requests and channel handshake, produces the grant
  modport master (
    input  user_req, chn_valid, chn_ready, chn_last,
    output grant_vld, grant_id, grant_oh, timeout_err, timeout_id
  );

  modport slave (
    output user_req, chn_valid, chn_ready, chn_last,
    input  grant_vld, grant_id, grant_oh, timeout_err, timeout_id
  );

endinterface
`default_nettype wire

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_interconnect_crossbar_arbit_polling : combinational round-robin pick  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module axi_interconnect_crossbar_arbit_polling #(
  parameter int NUM   = 8,
  parameter int WIDTH = 3
) (
  input  logic [NUM-1:0]   user_req,
  input  logic [WIDTH-1:0] last_user,
  output logic [WIDTH-1:0] current_user
);

  logic [WIDTH-1:0] w_idx;

  // Walk from the farthest candidate back toward last_user+1 so the nearest
  // requester overwrites; index arithmetic wraps naturally since NUM is 2^WIDTH.
  always_comb begin
    current_user = last_user;
    w_idx        = '0;
    for (int i = NUM; i >= 1; i--) begin
      w_idx = last_user + WIDTH'(i);
      if (user_req[w_idx]) begin
        current_user = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_interconnect_crossbar_grant_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_interconnect_crossbar_grant_ctrl : locked round-robin grant + watchdog|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module axi_interconnect_crossbar_grant_ctrl
  import axi_interconnect_pkg::*;
#(
  parameter int NUM     = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                                  clk_sys,
  input  logic                                  rst_n,
  axi_interconnect_crossbar_grant_ctrl_if.master bus
);

  localparam int WIDTH   = idx_width(NUM);
  localparam int c_cnt_w = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

  grant_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_last_user, w_last_user_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic                r_grant_vld, w_grant_vld_nxt;
  logic [WIDTH-1:0]    r_grant_id, w_grant_id_nxt;
  logic [NUM-1:0]      r_grant_oh, w_grant_oh_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic [WIDTH-1:0]    r_timeout_id, w_timeout_id_nxt;

  logic [WIDTH-1:0]    w_current_user;
  logic                w_beat;
  logic                w_wdog_hit;

  axi_interconnect_crossbar_arbit_polling #(
    .NUM   (NUM),
    .WIDTH (WIDTH)
  ) u_arbit (
    .user_req     (bus.user_req),
    .last_user    (r_last_user),
    .current_user (w_current_user)
  );

  assign w_beat = bus.chn_valid & bus.chn_ready;

  generate
    if (TIMEOUT != 0) begin : g_wdog
      assign w_wdog_hit = (r_cnt == c_cnt_w'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign w_wdog_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt       = r_state;
    w_last_user_nxt   = r_last_user;
    w_cnt_nxt         = r_cnt;
    w_grant_vld_nxt   = r_grant_vld;
    w_grant_id_nxt    = r_grant_id;
    w_grant_oh_nxt    = r_grant_oh;
    w_timeout_err_nxt = 1'b0;
    w_timeout_id_nxt  = r_timeout_id;
    case (r_state)
      ST_IDLE: begin
        w_grant_vld_nxt = 1'b0;
        w_grant_oh_nxt  = '0;
        if (|bus.user_req) begin
          w_state_nxt     = ST_GRANT;
          w_grant_vld_nxt = 1'b1;
          w_grant_id_nxt  = w_current_user;
          w_grant_oh_nxt  = NUM'(1) << w_current_user;
          w_cnt_nxt       = '0;
        end
      end
      ST_GRANT: begin
        // A completing beat outranks the watchdog in the same cycle
        if (w_beat && bus.chn_last) begin
          w_state_nxt     = ST_IDLE;
          w_last_user_nxt = r_grant_id;
          w_grant_vld_nxt = 1'b0;
          w_grant_oh_nxt  = '0;
        end else if (w_beat) begin
          w_cnt_nxt = '0;
        end else if (w_wdog_hit) begin
          w_state_nxt       = ST_IDLE;
          w_last_user_nxt   = r_grant_id;
          w_grant_vld_nxt   = 1'b0;
          w_grant_oh_nxt    = '0;
          w_timeout_err_nxt = 1'b1;
          w_timeout_id_nxt  = r_grant_id;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last_user   <= '0;
      r_cnt         <= '0;
      r_grant_vld   <= 1'b0;
      r_grant_id    <= '0;
      r_grant_oh    <= '0;
      r_timeout_err <= 1'b0;
      r_timeout_id  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_user   <= w_last_user_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grant_vld   <= w_grant_vld_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_oh    <= w_grant_oh_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_timeout_id  <= w_timeout_id_nxt;
    end
  end

  assign bus.grant_vld   = r_grant_vld;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_oh    = r_grant_oh;
  assign bus.timeout_err = r_timeout_err;
  assign bus.timeout_id  = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_axi_interconnect_crossbar_grant_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_interconnect_crossbar_grant_ctrl : vector table + scoreboard bench |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_axi_interconnect_crossbar_grant_ctrl;

  localparam int NUM     = 8;
  localparam int TIMEOUT = 16;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  axi_interconnect_crossbar_grant_ctrl_if #(.NUM(NUM)) bus ();

  axi_interconnect_crossbar_grant_ctrl #(
    .NUM     (NUM),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       rst_before;
    logic [7:0] req;
    logic [2:0] exp_id;
    int         nbeats;
  } vec_t;

  vec_t       vecs [13];
  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] m_last = '0;
  logic [2:0] sb_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Independent reference: forward scan from last+1, first requester wins
  function automatic logic [2:0] rr(input logic [7:0] req, input logic [2:0] last);
    for (int k = 1; k <= NUM; k++) begin
      int idx;
      idx = (int'(last) + k) % NUM;
      if (req[idx]) return 3'(idx);
    end
    return last;
  endfunction

  task automatic drive_idle_chn();
    bus.chn_valid = 1'b0;
    bus.chn_ready = 1'b0;
    bus.chn_last  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    rst_n        = 1'b0;
    bus.user_req = '0;
    drive_idle_chn();
    m_last = '0;
    sb_q.delete();
    @(negedge clk_sys);
    check("rst_grant_vld",   32'(bus.grant_vld),   32'd0);
    check("rst_grant_id",    32'(bus.grant_id),    32'd0);
    check("rst_grant_oh",    32'(bus.grant_oh),    32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_timeout_id",  32'(bus.timeout_id),  32'd0);
    rst_n = 1'b1;
  endtask

  // Called at a negedge after user_req is driven; returns at the grant negedge
  task automatic wait_grant(input logic [2:0] exp_id, output int waited);
    logic [2:0] m;
    logic [2:0] e;
    m = rr(bus.user_req, m_last);
    sb_q.push_back(exp_id);
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (!bus.grant_vld && waited < 8);
    e = sb_q.pop_front();
    if (!bus.grant_vld) begin
      check("grant_wait_expired", 32'(bus.grant_vld), 32'd1);
    end else begin
      check("grant_id",       32'(bus.grant_id), 32'(e));
      check("grant_rr_model", 32'(bus.grant_id), 32'(m));
      check("grant_oh",       32'(bus.grant_oh), 32'(8'd1 << e));
    end
  endtask

  task automatic run_beats(input int n, input logic [2:0] id);
    for (int b = 0; b < n; b++) begin
      bus.chn_valid = 1'b1;
      bus.chn_ready = 1'b1;
      bus.chn_last  = (b == n - 1);
      @(negedge clk_sys);
      if (b < n - 1) begin
        check("lock_vld", 32'(bus.grant_vld), 32'd1);
        check("lock_id",  32'(bus.grant_id),  32'(id));
      end
    end
    drive_idle_chn();
    check("release_vld",   32'(bus.grant_vld),   32'd0);
    check("release_oh",    32'(bus.grant_oh),    32'd0);
    check("release_noerr", 32'(bus.timeout_err), 32'd0);
    m_last = id;
  endtask

  initial begin
    int w;
    int cnt;

    // T2 then T3 (T3 starts from a fresh pointer)
    vecs[0]  = '{1'b1, 8'hFF, 3'd1, 1};
    vecs[1]  = '{1'b0, 8'hFF, 3'd2, 1};
    vecs[2]  = '{1'b0, 8'hFF, 3'd3, 1};
    vecs[3]  = '{1'b0, 8'hFF, 3'd4, 1};
    vecs[4]  = '{1'b0, 8'hFF, 3'd5, 1};
    vecs[5]  = '{1'b0, 8'hFF, 3'd6, 1};
    vecs[6]  = '{1'b0, 8'hFF, 3'd7, 1};
    vecs[7]  = '{1'b0, 8'hFF, 3'd0, 1};
    vecs[8]  = '{1'b0, 8'hFF, 3'd1, 1};
    vecs[9]  = '{1'b1, 8'h81, 3'd7, 1};
    vecs[10] = '{1'b0, 8'h81, 3'd0, 1};
    vecs[11] = '{1'b0, 8'h81, 3'd7, 1};
    vecs[12] = '{1'b0, 8'h81, 3'd0, 1};

    bus.user_req = '0;
    drive_idle_chn();

    // T1: idle with no requests
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      check("t1_idle_vld", 32'(bus.grant_vld),   32'd0);
      check("t1_idle_err", 32'(bus.timeout_err), 32'd0);
    end

    // T2/T3: table-driven rotation and wrap
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_before) apply_reset();
      bus.user_req = vecs[i].req;
      wait_grant(vecs[i].exp_id, w);
      check("grant_gap", 32'(w), 32'd1);
      run_beats(vecs[i].nbeats, vecs[i].exp_id);
    end

    // T4: lock through request changes and ready stalls, release on last
    apply_reset();
    bus.user_req = 8'h08;
    wait_grant(3'd3, w);
    bus.chn_valid = 1'b1;
    bus.chn_ready = 1'b1;
    bus.chn_last  = 1'b0;
    @(negedge clk_sys);
    bus.user_req  = 8'h20;
    bus.chn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("t4_stall_vld", 32'(bus.grant_vld), 32'd1);
      check("t4_stall_id",  32'(bus.grant_id),  32'd3);
    end
    run_beats(3, 3'd3);
    wait_grant(3'd5, w);
    check("t4_next_gap", 32'(w), 32'd1);
    run_beats(1, 3'd5);

    // T5: watchdog release after TIMEOUT silent cycles
    apply_reset();
    bus.user_req = 8'h04;
    wait_grant(3'd2, w);
    cnt = 0;
    while (bus.grant_vld && cnt < 40) begin
      check("t5_no_early_err", 32'(bus.timeout_err), 32'd0);
      @(negedge clk_sys);
      cnt++;
    end
    check("t5_timeout_cycles", 32'(cnt),             32'(TIMEOUT));
    check("t5_timeout_err",    32'(bus.timeout_err), 32'd1);
    check("t5_timeout_id",     32'(bus.timeout_id),  32'd2);
    check("t5_dropped_oh",     32'(bus.grant_oh),    32'd0);
    m_last = 3'd2;
    bus.user_req = 8'h14;
    wait_grant(3'd4, w);
    check("t5_err_pulse",   32'(bus.timeout_err), 32'd0);
    check("t5_id_held",     32'(bus.timeout_id),  32'd2);
    run_beats(1, 3'd4);

    // T6: asynchronous reset in the middle of a burst
    apply_reset();
    bus.user_req = 8'h40;
    wait_grant(3'd6, w);
    bus.chn_valid = 1'b1;
    bus.chn_ready = 1'b0;
    @(negedge clk_sys);
    check("t6_pre_id", 32'(bus.grant_id), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_vld", 32'(bus.grant_vld), 32'd0);
    check("t6_async_oh",  32'(bus.grant_oh),  32'd0);
    @(negedge clk_sys);
    drive_idle_chn();
    bus.user_req = 8'hFF;
    rst_n  = 1'b1;
    m_last = '0;
    wait_grant(3'd1, w);
    check("t6_first_gap", 32'(w), 32'd1);
    run_beats(1, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
